// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared encodings and sizes for the program loader
package prog_loader_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 8;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_RUN   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEN   = 2'b01,
        WDATA = 2'b10,
        RDATA = 2'b11
    } state_e;

endpackage

// File: rtl/prog_loader_sync2.sv
// rtl/prog_loader_sync2.sv - two-flop synchroniser for the asynchronous host strobe
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage time to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host byte handshake to CPU memory burst write/read and run/hold control
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_stb,
    input  logic [DW-1:0] host_data,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic [DW-1:0] chk
);

    logic          stb_s;
    state_e        state_q, state_d;
    logic          dir_rd_q, dir_rd_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          we_q, we_d;
    logic          ack_q, ack_d;
    logic          hold_q, hold_d;
    logic [DW-1:0] chk_q, chk_d;
    logic          accept;
    cmd_e          cmd;

    sync2 u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (host_stb),
        .q_o   (stb_s)
    );

    assign accept = stb_s && !ack_q;
    assign cmd    = cmd_e'(host_data[7:6]);

    // State and datapath registers; CPU is held out of reset until told to run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dir_rd_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            ack_q    <= 1'b0;
            hold_q   <= 1'b1;
            chk_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_rd_q <= dir_rd_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
            hold_q   <= hold_d;
            chk_q    <= chk_d;
        end
    end

    // Next-state: one accepted byte per handshake drives the burst machine.
    always_comb begin
        state_d  = state_q;
        dir_rd_d = dir_rd_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        ack_d    = ack_q;
        hold_d   = hold_q;
        chk_d    = chk_q;

        if (ack_q && !stb_s) begin
            ack_d = 1'b0;
        end

        // Writes advance the address one cycle late so it stays put under the pulse.
        if (we_q) begin
            addr_d = addr_q + 1'b1;
        end

        if (accept) begin
            ack_d = 1'b1;
            case (state_q)
                IDLE: begin
                    case (cmd)
                        CMD_WRITE, CMD_READ: begin
                            hold_d   = 1'b1;
                            addr_d   = host_data[AW-1:0];
                            chk_d    = '0;
                            dir_rd_d = (cmd == CMD_READ);
                            state_d  = LEN;
                        end
                        CMD_RUN: hold_d = 1'b0;
                        default: ;
                    endcase
                end
                LEN: begin
                    cnt_d   = host_data[AW-1:0];
                    state_d = dir_rd_q ? RDATA : WDATA;
                end
                WDATA: begin
                    wdata_d = host_data;
                    we_d    = 1'b1;
                    chk_d   = chk_q ^ host_data;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                RDATA: begin
                    rdata_d = mem_rdata;
                    chk_d   = chk_q ^ mem_rdata;
                    addr_d  = addr_q + 1'b1;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign host_ack   = ack_q;
    assign host_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = we_q;
    assign cpu_hold   = hold_q;
    assign busy       = (state_q != IDLE);
    assign chk        = chk_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for the program loader
module tb_prog_loader;

    logic       clk;
    logic       rst_n;
    logic       host_stb;
    logic [7:0] host_data;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       cpu_hold;
    logic       busy;
    logic [7:0] chk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem   [32];
    logic [7:0]  model [32];
    logic [12:0] wq [$];
    logic [7:0]  rq [$];
    int          we_cnt = 0;
    logic        prev_we = 1'b0;
    logic        ack_busy, ack_hold;

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_stb   (host_stb),
        .host_data  (host_data),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .chk        (chk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the next expected (addr, data) and last one cycle.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            we_cnt++;
            if (wq.size() == 0) begin
                check_eq("we_unexp", 1, 0);
            end else begin
                logic [12:0] e;
                e = wq.pop_front();
                check_eq("we_addr", mem_addr, e[12:8]);
                check_eq("we_data", mem_wdata, e[7:0]);
            end
            if (prev_we) check_eq("we_width", 2, 1);
        end
        prev_we = mem_we;
    end

    task automatic exp_write(input logic [4:0] a, input logic [7:0] d);
        wq.push_back({a, d});
        model[a] = d;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] rd);
        int n;
        host_data = b;
        host_stb  = 1'b1;
        n = 0;
        while (!host_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ack_rise_lat", n, 3);
        rd       = host_rdata;
        ack_busy = busy;
        ack_hold = cpu_hold;
        host_stb = 1'b0;
        n = 0;
        while (host_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ack_fall_lat", n, 3);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ack"}, host_ack, 0);
        check_eq({tag, "_rdata"}, host_rdata, 0);
        check_eq({tag, "_addr"}, mem_addr, 0);
        check_eq({tag, "_wdata"}, mem_wdata, 0);
        check_eq({tag, "_we"}, mem_we, 0);
        check_eq({tag, "_hold"}, cpu_hold, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_chk"}, chk, 0);
    endtask

    initial begin
        logic [7:0] rd;
        int         w0;
        logic [7:0] c0;
        logic [4:0] a0;

        for (int i = 0; i < 32; i++) begin
            mem[i]   = 8'h00;
            model[i] = 8'h00;
        end
        rst_n     = 1'b0;
        host_stb  = 1'b0;
        host_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of an accepted header
        host_data = 8'h45;
        host_stb  = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        host_stb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // WRITE burst: 3 bytes from address 5
        w0 = we_cnt;
        exp_write(5'd5, 8'hAA);
        exp_write(5'd6, 8'hBB);
        exp_write(5'd7, 8'hCC);
        send_byte(8'h45, rd);
        check_eq("wr_hold_hdr", ack_hold, 1);
        check_eq("wr_busy_hdr", ack_busy, 1);
        send_byte(8'h02, rd);
        send_byte(8'hAA, rd);
        send_byte(8'hBB, rd);
        check_eq("wr_busy_4", ack_busy, 1);
        send_byte(8'hCC, rd);
        check_eq("wr_busy_5", ack_busy, 0);
        check_eq("wr_we_cnt", we_cnt - w0, 3);
        check_eq("wr_chk", chk, 8'hDD);
        for (int i = 5; i < 8; i++) check_eq("wr_mem", mem[i], model[i]);

        // READ back the same three bytes
        w0 = we_cnt;
        for (int i = 5; i < 8; i++) rq.push_back(model[i]);
        send_byte(8'h85, rd);
        check_eq("rd_hold", ack_hold, 1);
        send_byte(8'h02, rd);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h5A, rd);
            check_eq("rd_data", rd, rq.pop_front());
        end
        check_eq("rd_busy", busy, 0);
        check_eq("rd_no_we", we_cnt - w0, 0);
        check_eq("rd_chk", chk, 8'hDD);

        // Address wrap 31 -> 0
        exp_write(5'd31, 8'h11);
        exp_write(5'd0, 8'h22);
        send_byte(8'h5F, rd);
        send_byte(8'h01, rd);
        send_byte(8'h11, rd);
        send_byte(8'h22, rd);
        check_eq("wrap_m31", mem[31], model[31]);
        check_eq("wrap_m0", mem[0], model[0]);
        check_eq("wrap_addr", mem_addr, 1);
        check_eq("wrap_chk", chk, 8'h33);

        // RUN releases the CPU on the accept edge; a WRITE header re-holds it
        send_byte(8'hC0, rd);
        check_eq("run_hold", ack_hold, 0);
        check_eq("run_busy", ack_busy, 0);
        exp_write(5'd0, 8'h5A);
        send_byte(8'h40, rd);
        check_eq("rehold", ack_hold, 1);
        send_byte(8'h00, rd);
        send_byte(8'h5A, rd);
        check_eq("rehold_mem0", mem[0], model[0]);

        // NOP changes nothing
        c0 = chk;
        a0 = mem_addr;
        w0 = we_cnt;
        send_byte(8'h00, rd);
        check_eq("nop_busy", ack_busy, 0);
        check_eq("nop_hold", cpu_hold, 1);
        check_eq("nop_chk", chk, c0);
        check_eq("nop_addr", mem_addr, a0);
        check_eq("nop_we", we_cnt - w0, 0);

        // Reset mid-burst: next byte is a header
        exp_write(5'd5, 8'hAA);
        send_byte(8'h45, rd);
        send_byte(8'h02, rd);
        send_byte(8'hAA, rd);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        w0 = we_cnt;
        send_byte(8'h00, rd);
        check_eq("mb_busy", ack_busy, 0);
        check_eq("mb_no_we", we_cnt - w0, 0);
        check_eq("mb_mem6", mem[6], model[6]);
        check_eq("mb_hold", cpu_hold, 1);

        repeat (4) @(negedge clk);
        check_eq("wq_left", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
